mac_fwd_lookup: RTL and testbench

- Downstream consumer of the MAC decoder's header FIFO (115-bit entries).
- Per frame: learns SRC MAC to ingress-port bindings in a small table and looks up the DST MAC.
- Emits exactly one forwarding-decision entry per header into the forward FIFO, so body-FIFO frames stay aligned one-to-one with decisions.
- Sits between the MAC decoder and the egress scheduler/body dispatcher.

---
 rtl/mac_fwd_lookup.sv | 220 ++++++++++++++++++++++
 tb/tb_mac_fwd_lookup.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/mac_fwd_lookup.sv
// MAC forwarding lookup: pops one header, searches a small learned MAC table one entry
// per cycle, learns the source binding, and pushes exactly one forwarding decision.
module mac_fwd_lookup #(
    parameter int AW = 4
) (
    input  logic         clk,
    input  logic         arst_n,
    input  logic [114:0] h_fifo_dout,
    input  logic         h_fifo_empty,
    output logic         h_fifo_rden,
    output logic [118:0] f_fifo_din,
    input  logic         f_fifo_full,
    output logic         f_fifo_wren,
    input  logic         tbl_clr
);

    localparam int ENTRIES = 1 << AW;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_READ   = 3'd1,
        S_LATCH  = 3'd2,
        S_SEARCH = 3'd3,
        S_LEARN  = 3'd4,
        S_EMIT   = 3'd5
    } state_t;

    state_t         state_q, state_d;
    logic [114:0]   hdr_q, hdr_d;
    logic [AW-1:0]  idx_q, idx_d;
    logic [AW-1:0]  src_idx_q, src_idx_d;
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic           dst_hit_q, dst_hit_d;
    logic           src_hit_q, src_hit_d;
    logic [1:0]     dst_port_q, dst_port_d;
    logic           clr_pend_q, clr_pend_d;
    logic           rden_q, rden_d;
    logic           wren_q, wren_d;
    logic [118:0]   din_q, din_d;

    logic [ENTRIES-1:0] tbl_valid_q;
    logic [47:0]        tbl_mac_q  [ENTRIES];
    logic [1:0]         tbl_port_q [ENTRIES];

    logic tbl_clr_all;
    logic tbl_new;
    logic tbl_upd;

    logic        fcs_ok;
    logic [1:0]  in_port;
    logic [47:0] dst_mac;
    logic [47:0] src_mac;
    logic        cur_valid;
    logic [47:0] cur_mac;
    logic [1:0]  cur_port;
    logic        dec_drop;
    logic [3:0]  dec_mask;

    assign fcs_ok    = hdr_q[114];
    assign in_port   = hdr_q[113:112];
    assign dst_mac   = hdr_q[111:64];
    assign src_mac   = hdr_q[63:16];
    assign cur_valid = tbl_valid_q[idx_q];
    assign cur_mac   = tbl_mac_q[idx_q];
    assign cur_port  = tbl_port_q[idx_q];

    assign h_fifo_rden = rden_q;
    assign f_fifo_wren = wren_q;
    assign f_fifo_din  = din_q;

    // Decision uses lookup results gathered before this frame's learn step.
    always_comb begin
        dec_drop = 1'b0;
        dec_mask = 4'b0000;
        if (!fcs_ok) begin
            dec_drop = 1'b1;
            dec_mask = 4'b0000;
        end else if (dst_mac[40] || !dst_hit_q) begin
            dec_drop = 1'b0;
            dec_mask = 4'b1111 & ~(4'b0001 << in_port);
        end else if (dst_port_q == in_port) begin
            dec_drop = 1'b1;
            dec_mask = 4'b0000;
        end else begin
            dec_drop = 1'b0;
            dec_mask = 4'b0001 << dst_port_q;
        end
    end

    always_comb begin
        state_d     = state_q;
        hdr_d       = hdr_q;
        idx_d       = idx_q;
        src_idx_d   = src_idx_q;
        wr_ptr_d    = wr_ptr_q;
        dst_hit_d   = dst_hit_q;
        src_hit_d   = src_hit_q;
        dst_port_d  = dst_port_q;
        clr_pend_d  = clr_pend_q;
        rden_d      = 1'b0;
        wren_d      = 1'b0;
        din_d       = din_q;
        tbl_clr_all = 1'b0;
        tbl_new     = 1'b0;
        tbl_upd     = 1'b0;

        if (state_q != S_IDLE && tbl_clr) begin
            clr_pend_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (clr_pend_q || tbl_clr) begin
                    tbl_clr_all = 1'b1;
                    clr_pend_d  = 1'b0;
                end else if (!h_fifo_empty && !f_fifo_full) begin
                    rden_d  = 1'b1;
                    state_d = S_READ;
                end
            end
            S_READ: begin
                state_d = S_LATCH;
            end
            S_LATCH: begin
                hdr_d     = h_fifo_dout;
                idx_d     = '0;
                dst_hit_d = 1'b0;
                src_hit_d = 1'b0;
                state_d   = S_SEARCH;
            end
            S_SEARCH: begin
                if (cur_valid && cur_mac == dst_mac) begin
                    dst_hit_d  = 1'b1;
                    dst_port_d = cur_port;
                end
                if (cur_valid && cur_mac == src_mac) begin
                    src_hit_d = 1'b1;
                    src_idx_d = idx_q;
                end
                idx_d = idx_q + 1'b1;
                if (idx_q == AW'(ENTRIES - 1)) begin
                    state_d = S_LEARN;
                end
            end
            S_LEARN: begin
                if (fcs_ok && !src_mac[40]) begin
                    if (src_hit_q) begin
                        tbl_upd = 1'b1;
                    end else begin
                        tbl_new  = 1'b1;
                        wr_ptr_d = wr_ptr_q + 1'b1;
                    end
                end
                state_d = S_EMIT;
            end
            S_EMIT: begin
                din_d   = {dec_drop, dec_mask, hdr_q[113:0]};
                wren_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                rden_d  = 1'b0;
                wren_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q    <= S_IDLE;
            hdr_q      <= '0;
            idx_q      <= '0;
            src_idx_q  <= '0;
            wr_ptr_q   <= '0;
            dst_hit_q  <= 1'b0;
            src_hit_q  <= 1'b0;
            dst_port_q <= 2'b00;
            clr_pend_q <= 1'b0;
            rden_q     <= 1'b0;
            wren_q     <= 1'b0;
            din_q      <= '0;
        end else begin
            state_q    <= state_d;
            hdr_q      <= hdr_d;
            idx_q      <= idx_d;
            src_idx_q  <= src_idx_d;
            wr_ptr_q   <= wr_ptr_d;
            dst_hit_q  <= dst_hit_d;
            src_hit_q  <= src_hit_d;
            dst_port_q <= dst_port_d;
            clr_pend_q <= clr_pend_d;
            rden_q     <= rden_d;
            wren_q     <= wren_d;
            din_q      <= din_d;
        end
    end

    // One register slice per table entry; clear has priority over any write.
    generate
        for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_entry
            always_ff @(posedge clk or negedge arst_n) begin
                if (!arst_n) begin
                    tbl_valid_q[gi] <= 1'b0;
                    tbl_mac_q[gi]   <= '0;
                    tbl_port_q[gi]  <= 2'b00;
                end else if (tbl_clr_all) begin
                    tbl_valid_q[gi] <= 1'b0;
                end else if (tbl_new && wr_ptr_q == AW'(gi)) begin
                    tbl_valid_q[gi] <= 1'b1;
                    tbl_mac_q[gi]   <= src_mac;
                    tbl_port_q[gi]  <= in_port;
                end else if (tbl_upd && src_idx_q == AW'(gi)) begin
                    tbl_port_q[gi]  <= in_port;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_mac_fwd_lookup.sv
// Directed bench for mac_fwd_lookup: drives single headers through a one-deep FIFO
// model and checks latency, pulse width and the forwarding decision of each frame.
module tb_mac_fwd_lookup;

    logic         clk;
    logic         arst_n;
    logic [114:0] h_fifo_dout;
    logic         h_fifo_empty;
    logic         h_fifo_rden;
    logic [118:0] f_fifo_din;
    logic         f_fifo_full;
    logic         f_fifo_wren;
    logic         tbl_clr;

    int checks = 0;
    int errors = 0;

    localparam logic [47:0] BC = 48'hFFFF_FFFF_FFFF;
    localparam logic [47:0] S1 = 48'h0011_2233_4455;
    localparam logic [47:0] S2 = 48'h00AA_0000_0002;
    localparam logic [47:0] S3 = 48'h00BB_0000_0003;
    localparam logic [47:0] MC = 48'h0100_0000_0099;

    mac_fwd_lookup #(.AW(4)) dut (
        .clk          (clk),
        .arst_n       (arst_n),
        .h_fifo_dout  (h_fifo_dout),
        .h_fifo_empty (h_fifo_empty),
        .h_fifo_rden  (h_fifo_rden),
        .f_fifo_din   (f_fifo_din),
        .f_fifo_full  (f_fifo_full),
        .f_fifo_wren  (f_fifo_wren),
        .tbl_clr      (tbl_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [118:0] obs, input logic [118:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [114:0] mk(input logic fcs, input logic [1:0] port,
                                        input logic [47:0] dst, input logic [47:0] src);
        return {fcs, port, dst, src, 16'h0800};
    endfunction

    // Offer one header, wait for the pop and the decision, then check everything.
    task automatic send(input string tag, input logic [114:0] h, input logic drop,
                        input logic [3:0] mask, input int clr_at);
        int  n;
        int  lat;
        bit  seen;
        logic [118:0] exp;
        h_fifo_dout  = h;
        h_fifo_empty = 1'b0;
        n = 0;
        seen = 0;
        while (n < 100 && !seen) begin
            @(negedge clk);
            n++;
            if (h_fifo_rden) seen = 1;
        end
        chk({tag, "_rden"}, 119'(seen), 119'(1));
        h_fifo_empty = 1'b1;
        lat = 0;
        seen = 0;
        while (lat < 100 && !seen) begin
            @(negedge clk);
            lat++;
            tbl_clr = (lat == clr_at);
            if (f_fifo_wren) seen = 1;
        end
        tbl_clr = 1'b0;
        chk({tag, "_lat"}, 119'(lat), 119'(20));
        exp = {drop, mask, h[113:0]};
        chk({tag, "_din"}, f_fifo_din, exp);
        @(negedge clk);
        chk({tag, "_pulse"}, 119'(f_fifo_wren), 119'(0));
        $display("frame %s: drop=%b mask=%b latency=%0d", tag, f_fifo_din[118],
                 f_fifo_din[117:114], lat);
    endtask

    initial begin
        bit rd_seen;
        arst_n       = 1'b0;
        h_fifo_dout  = '0;
        h_fifo_empty = 1'b1;
        f_fifo_full  = 1'b0;
        tbl_clr      = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_rden", 119'(h_fifo_rden), 119'(0));
        chk("rst_wren", 119'(f_fifo_wren), 119'(0));
        chk("rst_din", f_fifo_din, 119'(0));
        arst_n = 1'b1;
        repeat (2) @(negedge clk);

        send("A_bcast",    mk(1'b1, 2'd0, BC, S1), 1'b0, 4'b1110, 0);
        send("B_known",    mk(1'b1, 2'd2, S1, S2), 1'b0, 4'b0001, 0);
        send("C_badfcs",   mk(1'b0, 2'd1, S1, S3), 1'b1, 4'b0000, 0);
        send("D_nolearn",  mk(1'b1, 2'd0, S3, MC), 1'b0, 4'b1110, 0);
        send("E_filter",   mk(1'b1, 2'd0, S1, S1), 1'b1, 4'b0000, 0);
        send("F_move",     mk(1'b1, 2'd3, BC, S1), 1'b0, 4'b0111, 0);
        send("G_moved",    mk(1'b1, 2'd0, S1, MC), 1'b0, 4'b1000, 0);
        send("H_s2",       mk(1'b1, 2'd1, S2, MC), 1'b0, 4'b0100, 0);

        // Entries 2..15 fill; wr_ptr wraps to 0 only if the move added no entry.
        for (int k = 0; k < 14; k++) begin
            send("W_fill", mk(1'b1, 2'd1, BC, {40'h00CC_0000_00, 8'(k)}), 1'b0, 4'b1101, 0);
        end
        send("I_s1_still", mk(1'b1, 2'd2, S1, MC), 1'b0, 4'b1000, 0);
        send("J_wrap",     mk(1'b1, 2'd1, BC, 48'h00CC_0000_00FF), 1'b0, 4'b1101, 0);
        send("K_s1_gone",  mk(1'b1, 2'd2, S1, MC), 1'b0, 4'b1011, 0);
        send("L_s2_kept",  mk(1'b1, 2'd0, S2, MC), 1'b0, 4'b0100, 0);

        h_fifo_empty = 1'b0;
        f_fifo_full  = 1'b1;
        rd_seen = 0;
        repeat (60) begin
            @(negedge clk);
            if (h_fifo_rden) rd_seen = 1;
        end
        chk("full_norden", 119'(rd_seen), 119'(0));
        $display("full hold: rden_seen=%0b", rd_seen);
        h_fifo_empty = 1'b1;
        f_fifo_full  = 1'b0;
        @(negedge clk);

        send("M_clr_inflt", mk(1'b1, 2'd0, S2, MC), 1'b0, 4'b0100, 5);
        send("N_after_clr", mk(1'b1, 2'd0, S2, MC), 1'b0, 4'b1110, 0);
        send("O_self",      mk(1'b1, 2'd1, S3, S3), 1'b0, 4'b1101, 0);
        send("P_self_lrn",  mk(1'b1, 2'd0, S3, MC), 1'b0, 4'b0010, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
